// File: rtl/hps_mag_writer.sv
// Write side of the HPS magnitude RAM: squares and sums FFT bins into RAM, then holds the stream until the reader is done.
// Define HPS_MAG_SAT_EN to saturate magnitudes that overflow MAG_WIDTH instead of wrapping them.
module hps_mag_writer #(
  parameter int K_WIDTH    = 12,
  parameter int DATA_WIDTH = 16,
  parameter int MAG_WIDTH  = 24,
  parameter int MAG_SHIFT  = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_re,
  input  logic signed [DATA_WIDTH-1:0] s_im,
  input  logic                         s_last,
  output logic                         ram_we,
  output logic [K_WIDTH-1:0]           ram_waddr,
  output logic [MAG_WIDTH-1:0]         ram_wdata,
  output logic                         fft_last,
  input  logic                         reader_done,
  output logic                         busy,
  output logic                         frame_err
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = PROD_W + 1;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic logic [PROD_W-1:0] square(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [PROD_W-1:0] xe;
    logic signed [PROD_W-1:0] p;
    xe = {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};
    p  = xe * xe;
    return p;
  endfunction

  function automatic logic [MAG_WIDTH-1:0] mag_reduce(input logic [PROD_W-1:0] a,
                                                      input logic [PROD_W-1:0] b);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, a} + {1'b0, b};
`ifdef HPS_MAG_SAT_EN
    if (|(sum >> (MAG_SHIFT + MAG_WIDTH))) begin
      return {MAG_WIDTH{1'b1}};
    end else begin
      return MAG_WIDTH'(sum >> MAG_SHIFT);
    end
`else
    return MAG_WIDTH'(sum >> MAG_SHIFT);
`endif
  endfunction

  state_t                state_r;
  state_t                state_s;
  logic [K_WIDTH-1:0]    cnt_r;
  logic                  accept_s;
  logic                  at_max_s;
  logic                  frame_end_s;
  logic                  len_err_s;
  logic                  fft_last_s;

  logic                  s1_we_r;
  logic                  s1_last_r;
  logic [K_WIDTH-1:0]    s1_addr_r;
  logic [PROD_W-1:0]     s1_re2_r;
  logic [PROD_W-1:0]     s1_im2_r;
  logic                  s2_last_r;

  // Handshake and frame-length decode for the current input beat.
  always_comb begin
    accept_s    = s_valid && s_ready;
    at_max_s    = (cnt_r == {K_WIDTH{1'b1}});
    frame_end_s = accept_s && (s_last || at_max_s);
    len_err_s   = accept_s && (s_last != at_max_s);
  end

  // Next-state logic; DRAIN ends on the write carrying the frame's last flag.
  always_comb begin
    state_s    = state_r;
    fft_last_s = 1'b0;
    case (state_r)
      ST_FILL: begin
        if (frame_end_s) state_s = ST_DRAIN;
        else             state_s = ST_FILL;
      end
      ST_DRAIN: begin
        if (ram_we && s2_last_r) begin
          state_s    = ST_HOLD;
          fft_last_s = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (reader_done) state_s = ST_FILL;
        else             state_s = ST_HOLD;
      end
      default: begin
        state_s = ST_FILL;
      end
    endcase
  end

  // State register, registered status outputs and the bin counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_FILL;
      s_ready   <= 1'b1;
      busy      <= 1'b0;
      fft_last  <= 1'b0;
      frame_err <= 1'b0;
      cnt_r     <= {K_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      s_ready   <= (state_s == ST_FILL);
      busy      <= (state_s != ST_FILL);
      fft_last  <= fft_last_s;
      frame_err <= frame_err | len_err_s;
      if (frame_end_s) begin
        cnt_r <= {K_WIDTH{1'b0}};
      end else if (accept_s) begin
        cnt_r <= cnt_r + {{(K_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Stage 1: squares of both components plus address and frame-end tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_we_r   <= 1'b0;
      s1_last_r <= 1'b0;
      s1_addr_r <= {K_WIDTH{1'b0}};
      s1_re2_r  <= {PROD_W{1'b0}};
      s1_im2_r  <= {PROD_W{1'b0}};
    end else begin
      s1_we_r   <= accept_s;
      s1_last_r <= frame_end_s;
      if (accept_s) begin
        s1_addr_r <= cnt_r;
        s1_re2_r  <= square(s_re);
        s1_im2_r  <= square(s_im);
      end
    end
  end

  // Stage 2: scaled magnitude drives the RAM write port directly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_we    <= 1'b0;
      s2_last_r <= 1'b0;
      ram_waddr <= {K_WIDTH{1'b0}};
      ram_wdata <= {MAG_WIDTH{1'b0}};
    end else begin
      ram_we    <= s1_we_r;
      s2_last_r <= s1_we_r && s1_last_r;
      if (s1_we_r) begin
        ram_waddr <= s1_addr_r;
        ram_wdata <= mag_reduce(s1_re2_r, s1_im2_r);
      end
    end
  end

endmodule

// File: tb/tb_hps_mag_writer.sv
// Self-checking bench for hps_mag_writer: timestamped expectation model plus literal spot checks.
module tb_hps_mag_writer;

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic signed [15:0] s_re = 16'sd0;
  logic signed [15:0] s_im = 16'sd0;
  logic               s_last = 1'b0;
  logic               ram_we;
  logic [11:0]        ram_waddr;
  logic [23:0]        ram_wdata;
  logic               fft_last;
  logic               reader_done = 1'b0;
  logic               busy;
  logic               frame_err;

  hps_mag_writer dut (
    .clock(clock), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_re(s_re), .s_im(s_im), .s_last(s_last), .ram_we(ram_we),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .fft_last(fft_last),
    .reader_done(reader_done), .busy(busy), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct { longint due; int addr; int data; } wr_t;
  typedef struct { int addr; int data; } obs_t;

  int     checks = 0;
  int     errors = 0;
  wr_t    wq[$];
  obs_t   log_q[$];
  longint cyc = 0;
  longint fl_due = -1;
  longint hold_edge = 0;
  bit     waiting = 1'b0;
  bit     m_err = 1'b0;
  bit     exp_we = 1'b0;
  bit     cmp_on = 1'b1;
  int     idx = 0;
  int     fl_count = 0;
  int     n = 0;

  function automatic int model_mag(input int re, input int im);
    longint s;
    longint sh;
    s  = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    sh = s >> 8;
`ifdef HPS_MAG_SAT_EN
    if (sh > longint'(24'hFFFFFF)) sh = longint'(24'hFFFFFF);
`endif
    return int'(sh & longint'(24'hFFFFFF));
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int re, input int im, input bit last, input bit rd);
    @(negedge clock);
    s_valid     = v;
    s_re        = 16'(re);
    s_im        = 16'(im);
    s_last      = last;
    reader_done = rd;
  endtask

  // Model: each accepted sample becomes a timestamped write; frame end schedules fft_last and the hold window.
  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      wq.delete();
      waiting = 1'b0;
      idx     = 0;
      m_err   = 1'b0;
      fl_due  = -1;
    end else begin
      cyc++;
      if (waiting) begin
        if (cyc >= hold_edge && reader_done) waiting = 1'b0;
      end else if (s_valid) begin
        wq.push_back('{due: cyc + 1, addr: idx, data: model_mag(int'(s_re), int'(s_im))});
        if (s_last != (idx == 4095)) m_err = 1'b1;
        if (s_last || idx == 4095) begin
          idx       = 0;
          waiting   = 1'b1;
          fl_due    = cyc + 2;
          hold_edge = cyc + 3;
        end else begin
          idx++;
        end
      end
    end
  end

  // Per-cycle compare against the model, and a log of observed writes for spot checks.
  initial forever begin
    @(negedge clock);
    if (cmp_on) begin
      exp_we = (wq.size() > 0 && wq[0].due == cyc);
      check("ram_we", longint'(ram_we), longint'(exp_we));
      if (exp_we) begin
        check("ram_waddr", longint'(ram_waddr), longint'(wq[0].addr));
        check("ram_wdata", longint'(ram_wdata), longint'(wq[0].data));
        void'(wq.pop_front());
      end
      check("fft_last", longint'(fft_last), longint'(cyc == fl_due));
      check("s_ready", longint'(s_ready), longint'(!waiting));
      check("busy", longint'(busy), longint'(waiting));
      check("frame_err", longint'(frame_err), longint'(m_err));
      if (ram_we) log_q.push_back('{addr: int'(ram_waddr), data: int'(ram_wdata)});
      if (fft_last) fl_count++;
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_we", longint'(ram_we), 0);
    check("rst_waddr", longint'(ram_waddr), 0);
    check("rst_wdata", longint'(ram_wdata), 0);
    check("rst_fft_last", longint'(fft_last), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_frame_err", longint'(frame_err), 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    #1;
    check("ready_after_release", longint'(s_ready), 1);

    // Full 4096-bin frame, then stalled input while held.
    for (int k = 0; k < 4096; k++) drive(1'b1, k, 0, k == 4095, 1'b0);
    for (int k = 0; k < 20; k++) drive(1'b1, 7, 7, 1'b0, 1'b0);
    #1;
    check("full_count", longint'(log_q.size()), 4096);
    check("full_addr4095", longint'(log_q[4095].addr), 4095);
    check("full_data4095", longint'(log_q[4095].data), 65504);
    check("full_data100", longint'(log_q[100].data), 39);
    check("full_fft_pulses", longint'(fl_count), 1);
    check("full_frame_err", longint'(frame_err), 0);
    check("hold_ready", longint'(s_ready), 0);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    log_q.delete();
    fl_count = 0;

    // Short frame with extreme values; reader_done during DRAIN must be ignored.
    drive(1'b1, -32768, -32768, 1'b0, 1'b0);
    drive(1'b1, 32767, 32767, 1'b0, 1'b0);
    for (int i = 2; i < 10; i++) drive(1'b1, 16 * i, 0, i == 9, i == 9);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
    #1;
    check("short_count", longint'(log_q.size()), 10);
    check("sat_min_data", longint'(log_q[0].data), longint'(24'h800000));
    check("sat_max_data", longint'(log_q[1].data), longint'(24'h7FFE00));
    check("short_data5", longint'(log_q[5].data), 25);
    check("short_addr9", longint'(log_q[9].addr), 9);
    check("short_fft_pulses", longint'(fl_count), 1);
    check("short_busy", longint'(busy), 1);
    check("short_frame_err", longint'(frame_err), 1);
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    log_q.delete();

    // Gapped input then a contiguous run up to 100 samples, interrupted by reset.
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) begin
        drive(1'b1, 32 * (n + 1), 0, 1'b0, 1'b0);
        n++;
      end else begin
        drive(1'b0, 0, 0, 1'b0, 1'b0);
      end
    end
    for (int i = 0; i < 96; i++) begin
      drive(1'b1, 32 * (n + 1), 0, 1'b0, 1'b0);
      n++;
    end
    #1;
    check("gap_addr3", longint'(log_q[3].addr), 3);
    check("gap_data3", longint'(log_q[3].data), 64);
    check("gap_addr4", longint'(log_q[4].addr), 4);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_we", longint'(ram_we), 0);
    s_valid = 1'b0;
    log_q.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
    #1;
    check("midrst_no_writes", longint'(log_q.size()), 0);
    check("midrst_frame_err", longint'(frame_err), 0);
    check("midrst_ready", longint'(s_ready), 1);

    // Fresh frame after reset starts at bin 0.
    for (int i = 1; i <= 3; i++) drive(1'b1, 160 * i, 0, i == 3, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
    #1;
    check("post_count", longint'(log_q.size()), 3);
    check("post_addr0", longint'(log_q[0].addr), 0);
    check("post_data0", longint'(log_q[0].data), 100);
    check("post_data2", longint'(log_q[2].data), 900);
    check("post_frame_err", longint'(frame_err), 1);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
